// File: rtl/obi_hart_rr_arbiter.sv
// obi_hart_rr_arbiter: shares one OBI master port among NHARTS requesters.
// It uses round-robin selection and holds the selection while an address phase is stalled.
// An in-order id FIFO routes each response back to the hart that issued it.
package obi_hart_rr_arbiter_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_hart_rr_arbiter
   import obi_hart_rr_arbiter_pkg::*;
#(
   parameter int NHARTS          = 3,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  obi_req_t  [NHARTS-1:0]   hart_req_i,
   output obi_resp_t [NHARTS-1:0]   hart_resp_o,
   output obi_req_t                 bus_req_o,
   input  obi_resp_t                bus_resp_i,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int IDW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e           state_q;
   logic [IDW-1:0]   lock_idx_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic             err_q;

   logic [IDW-1:0]   sel_rr, sel, head;
   logic             found, any_req, full, lock, hs, pop;
   int               idx;

   assign lock = (state_q == ST_LOCKED);
   assign full = (cnt_q == CW'(MAX_OUTSTANDING));
   assign head = fifo_q[rd_q];

   // first requester at or after the rr pointer, wrapping around
   always_comb begin
      sel_rr = ptr_q;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NHARTS; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NHARTS) idx = idx - NHARTS;
         if (!found && hart_req_i[idx].req) begin
            found  = 1'b1;
            sel_rr = IDW'(idx);
         end
      end
   end

   // a stalled address phase pins the selection so the bus request stays stable
   assign sel     = lock ? lock_idx_q : sel_rr;
   assign any_req = lock ? hart_req_i[lock_idx_q].req : found;

   // forward the selected request; nothing goes out while the id FIFO is full
   always_comb begin
      bus_req_o = '0;
      if (any_req && !full) bus_req_o = hart_req_i[sel];
   end

   assign hs  = bus_req_o.req & bus_resp_i.gnt;
   assign pop = bus_resp_i.rvalid & (cnt_q != '0);

   // grant to the selected hart, response data to the FIFO head only
   always_comb begin
      for (int h = 0; h < NHARTS; h++) begin
         hart_resp_o[h]     = '0;
         hart_resp_o[h].gnt = hs && (sel == IDW'(h));
         if (pop && (head == IDW'(h))) begin
            hart_resp_o[h].rvalid = 1'b1;
            hart_resp_o[h].rdata  = bus_resp_i.rdata;
         end
      end
   end

   // lock FSM: enter on a stalled request, leave on its grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         lock_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus_req_o.req && !bus_resp_i.gnt) begin
                  state_q    <= ST_LOCKED;
                  lock_idx_q <= sel;
               end
            end
            ST_LOCKED: begin
               if (hs) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // rr pointer moves past the hart that just handshook
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else if (hs) ptr_q <= (sel == IDW'(NHARTS - 1)) ? '0 : sel + 1'b1;
   end

   // in-flight id FIFO: push on handshake, pop on response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      end else begin
         if (hs) begin
            fifo_q[wr_q] <= sel;
            wr_q <= (wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop) rd_q <= (rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
         case ({hs, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // sticky flag for a response nobody is waiting for
   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else if (bus_resp_i.rvalid && (cnt_q == '0)) err_q <= 1'b1;
   end

   assign err_o  = err_q;
   assign busy_o = (cnt_q != '0) | lock;

endmodule
